// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared 8-bit BlockRAM/peripheral bus.
// Define MEM_BUS_ARBITER_LOCK_EN to let a locked owner keep the bus for up to MAX_BURST re-grants.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                pick1;

`ifdef MEM_BUS_ARBITER_LOCK_EN
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       grant_locked;

    // Locked re-grant of the previous owner overrides round-robin until the burst budget is spent.
    always_comb begin
        pick1        = req1 && (!req0 || !last_grant_q);
        grant_locked = 1'b0;
        if ((last_grant_q ? (lock1 && req1) : (lock0 && req0)) && (burst_cnt_q != BURST_MAX)) begin
            pick1        = last_grant_q;
            grant_locked = 1'b1;
        end
    end
`else
    logic [2:0] unused_lock;
    assign unused_lock = {lock0, lock1, MAX_BURST == 0};

    // On a tie the port that did not win last time is granted.
    always_comb begin
        pick1 = req1 && (!req0 || !last_grant_q);
    end
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
`ifdef MEM_BUS_ARBITER_LOCK_EN
        burst_cnt_d  = burst_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d      = pick1;
                    last_grant_d = pick1;
                    addr_d       = pick1 ? addr1 : addr0;
                    we_d         = pick1 ? we1 : we0;
                    wdata_d      = pick1 ? wdata1 : wdata0;
                    state_d      = S_ACCESS;
`ifdef MEM_BUS_ARBITER_LOCK_EN
                    burst_cnt_d  = grant_locked ? burst_cnt_q + 8'd1 : 8'd0;
`endif
                end
            end
            S_ACCESS: begin
                // Read data is only captured for reads; a write leaves the owner's rdata alone.
                if (!we_q) begin
                    if (owner_q) rdata1_d = mem_data_in;
                    else         rdata0_d = mem_data_in;
                end
                if (owner_q) ack1_d = 1'b1;
                else         ack0_d = 1'b1;
                we_d    = 1'b0;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef MEM_BUS_ARBITER_LOCK_EN
            burst_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
`ifdef MEM_BUS_ARBITER_LOCK_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

    assign mem_address  = addr_q;
    assign mem_write_en = we_q;
    assign mem_data_out = wdata_q;
    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit block RAM / peripheral bus (19-bit address, 8-bit data, write enable) between two requesters: port 0 (CPU-side bridge) and port 1 (DMA / program loader).
- Per-port req/ack handshake. Registered, fixed-latency access. Round-robin fairness.
- Sits between the requesters and the BlockRAM/LEDPanel bus in the FPGA top level.

Parameters:
- ADDR_W, 19, address width of bus and both ports.
- DATA_W, 8, data width.
- MAX_BURST, 16, maximum consecutive grants to one locked owner (used only with the optional feature); range 1..255.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request.
- addr0  in  ADDR_W  port 0 address.
- we0  in  1  port 0 write (1) / read (0).
- wdata0  in  DATA_W  port 0 write data.
- lock0  in  1  port 0 burst lock (optional feature only).
- ack0  out  1  port 0 completion pulse.
- rdata0  out  DATA_W  port 0 read data, valid while ack0=1.
- req1, addr1, we1, wdata1, lock1, ack1, rdata1: same as port 0, for port 1.
- mem_address  out  ADDR_W  shared bus address.
- mem_write_en  out  1  shared bus write strobe.
- mem_data_out  out  DATA_W  data to memory/peripherals.
- mem_data_in  in  DATA_W  combinational read data from memory/peripherals.

Behaviour:
- Clock/reset: single clock `clock`; reset is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0 (mem_address=0, mem_write_en=0, mem_data_out=0, ack0/1=0, rdata0/1=0), last_grant=1 (port 0 wins the first tie), burst_cnt=0.
- The FSM states below are all registered:
  - IDLE: sample req0/req1.
    - None: stay in IDLE.
    - One: grant that port.
    - Both: grant the port that is not last_grant.
    - On grant, at the edge: latch addr/we/wdata of the winner into mem_address/mem_write_en/mem_data_out, set owner and last_grant, go to ACCESS.
  - ACCESS (1 cycle): bus is driven with the latched values. mem_write_en equals the latched we. At the edge:
    - capture mem_data_in into rdata[owner] (reads only; writes leave rdata unchanged);
    - assert ack[owner];
    - clear mem_write_en;
    - go to ACK.
  - ACK (1 cycle): ack[owner]=1 for exactly this cycle. mem_address holds its value. Next state is IDLE.
- Latency: req high at edge N → bus driven in cycle N+1 → ack high in cycle N+2. One access per 3 cycles minimum.
- Requester rules:
  - Hold req/addr/we/wdata stable from req assertion until the edge at which ack is seen high.
  - At that edge the requester may drop req or present the next transaction. It is not sampled before the next IDLE.
  - Dropping req before ack is illegal. The arbiter ignores it because the transaction is already latched.
- Only one ack is ever high per cycle. ack never asserts for a port that did not win.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1,...
- Writes reach memory exactly once per write grant: mem_write_en is high for exactly one cycle (ACCESS).
- Reset mid-operation:
  - If reset is sampled at the edge ending ACCESS, the write strobed in that cycle still completes (mem_write_en is registered and was already high).
  - No ack is generated; state returns to IDLE with outputs per the reset values.
  - A reset sampled in ACK suppresses nothing already done; ack drops next cycle.
- Address/data widths pass straight through. No arithmetic or remapping in the arbiter.

Optional Feature:
- Macro: MEM_BUS_ARBITER_LOCK_EN
- Defined:
  - In IDLE, if last owner's lock is high and its req is high, that port is re-granted regardless of the other req.
  - burst_cnt increments per locked re-grant. When burst_cnt reaches MAX_BURST, the lock is ignored for one arbitration and the normal round-robin rule applies; burst_cnt clears on any change of owner or when lock is low.
- Undefined: lock0/lock1 are ignored (ports remain, unused); no burst_cnt register; pure round-robin.

Test Plan:
- Reset → all outputs 0. Single port-0 read at addr 0x0FF05 with mem_data_in=0xA5 → mem_address=0x0FF05 in cycle N+1, ack0=1 and rdata0=0xA5 in cycle N+2, ack1 stays 0.
- Port 1 write addr 0x0FF10 data 0x3C → mem_write_en high exactly one cycle with mem_data_out=0x3C, ack1 one cycle later, rdata1 unchanged.
- req0 and req1 both held for 6 transactions from reset → grant order 0,1,0,1,0,1, one ack per 3 cycles, never both acks together.
- Reset asserted in the ACCESS cycle of a port-0 write → the write strobe occurs that cycle, no ack0, state IDLE next cycle; a new req1 is then serviced normally.
- Requester changes addr0 during ACCESS → mem_address keeps the latched value; ack0 is returned for the original transaction.
- With MEM_BUS_ARBITER_LOCK_EN, MAX_BURST=4, port 0 locked, both reqs held → grant order 0,0,0,0,0,1,0,... (port 1 is granted after the counter saturates). Without the macro → 0,1,0,1,....
